// File: rtl/dm_bytelane.sv
// Byte-lane data memory: byte/half/word stores, sign/zero-extended loads, 1-cycle registered response.
// Define DM_TRACE_EN to add the PC port and print every legal store.
module dm_bytelane #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] ADDR,
  input  logic [31:0] data_in,
`ifdef DM_TRACE_EN
  input  logic [31:0] PC,
`endif
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] data_out,
  output logic        err,
  output logic        busy
);

  localparam int NUM_LANES = 4;
  localparam int IW        = $clog2(DEPTH_WORDS);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   clr_idx;
  logic            clearing;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= CLEAR;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_idx == IW'(DEPTH_WORDS - 1)) state_nxt = IDLE;
  end

  always_comb begin
    busy      = (state == CLEAR);
    req_ready = (state == IDLE);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)               clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + IW'(1);

  assign clearing = (state == CLEAR) & ~reset;

  // ---------------- request decode ----------------
  logic [31:0] word_idx;
  logic        req_err, accept, st_ok;
  logic [31:0] wd_rep;

  assign word_idx = (ADDR - BASE_ADDR) >> 2;
  assign req_err  = (req_size == 2'b11)
                  | (req_size == 2'b01 & ADDR[0])
                  | (req_size == 2'b10 & |ADDR[1:0])
                  | (word_idx >= 32'(DEPTH_WORDS));
  assign accept   = req_valid & req_ready;
  assign st_ok    = accept & req_we & ~req_err & ~reset;

  // Replicate the right-justified store data so each lane can pick its own byte.
  always_comb begin
    case (req_size)
      2'b00:   wd_rep = {4{data_in[7:0]}};
      2'b01:   wd_rep = {2{data_in[15:0]}};
      default: wd_rep = data_in;
    endcase
  end

  // ---------------- byte lanes ----------------
  logic [IW-1:0]                 lane_addr;
  logic [NUM_LANES-1:0]          lane_sel, lane_we;
  logic [NUM_LANES-1:0][7:0]     lane_wd, lane_rd;
`ifdef DM_TRACE_EN
  logic [NUM_LANES-1:0][7:0]     trace_word;
`endif

  assign lane_addr = clearing ? clr_idx : word_idx[IW-1:0];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    assign lane_sel[l] = (req_size == 2'b10)
                       | (req_size == 2'b01 & ADDR[1] == LN[1])
                       | (req_size == 2'b00 & ADDR[1:0] == LN);
    assign lane_we[l]  = clearing | (st_ok & lane_sel[l]);
    assign lane_wd[l]  = clearing ? 8'h00 : wd_rep[8*l +: 8];
    assign lane_rd[l]  = rd_q;

    always_ff @(posedge clk) begin
      if (lane_we[l]) mem[lane_addr] <= lane_wd[l];
      rd_q <= mem[lane_addr];
    end

`ifdef DM_TRACE_EN
    assign trace_word[l] = lane_sel[l] ? lane_wd[l] : mem[lane_addr];
`endif
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk)
    if (st_ok) $display("@%08h: *%08h <= %08h", PC, {ADDR[31:2], 2'b00}, trace_word);
`endif

  // ---------------- response stage ----------------
  logic       vld_q, err_q, ld_q, uns_q;
  logic [1:0] size_q, ofs_q;
  logic [31:0] shifted, ext;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      ofs_q  <= 2'b00;
    end else begin
      vld_q  <= accept;
      err_q  <= accept & req_err;
      ld_q   <= accept & ~req_we & ~req_err;
      uns_q  <= req_unsigned;
      size_q <= req_size;
      ofs_q  <= ADDR[1:0];
    end

  // Lane extraction works off the word captured at the acceptance edge.
  assign shifted = lane_rd >> {ofs_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   ext = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
      2'b01:   ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign rsp_valid = vld_q;
  assign err       = err_q;
  assign data_out  = ld_q ? ext : 32'h0;

endmodule
